// File: rtl/pc_ctrl_abc_pkg.sv
// Shared definitions for the ABC program-counter stage: FSM state encoding
// and default widths.
package pc_ctrl_abc_pkg;

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sRUN  = 2'd1,
        sHALT = 2'd2
    } pc_state_e;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 5;

endpackage

// File: rtl/branch_lut_abc.sv
// Branch-target table: register array with one write port, one combinational
// read port and a synchronous active-low clear of every entry.
module branch_lut_abc #(
    parameter int AW = 5,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_ctrl_abc.sv
// Program-counter / branch-resolution stage for the ABC core.
// Optional taken-branch counter built only when PC_PERF_EN is defined.
module pc_ctrl_abc
    import pc_ctrl_abc_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              LUT_AW     = LUT_AW_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              STALL,
    input  logic              BRANCH_EN,
    input  logic              BR_FLAG,
    input  logic [LUT_AW-1:0] BR_IDX,
    input  logic              HALT_REQ,
    input  logic              LUT_WE,
    input  logic [LUT_AW-1:0] LUT_WADDR,
    input  logic [PC_W-1:0]   LUT_WDATA,
    output logic [PC_W-1:0]   PC,
    output logic              FETCH_VALID,
    output logic              DONE,
    output logic [15:0]       TAKEN_CNT,
    output pc_state_e         STATE
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut_target;
    logic            lut_we_ok;

    // The table is frozen while a program runs so targets cannot shift mid-flight.
    assign lut_we_ok = LUT_WE && (state_q != sRUN);

    branch_lut_abc #(
        .AW(LUT_AW),
        .DW(PC_W)
    ) u_lut (
        .clk  (CLK),
        .rst_n(RESET_N),
        .we   (lut_we_ok),
        .waddr(LUT_WADDR),
        .wdata(LUT_WDATA),
        .raddr(BR_IDX),
        .rdata(lut_target)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= sIDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // RUN priority: stall > halt > taken branch > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            sIDLE: begin
                pc_d = START_ADDR;
                if (START) begin
                    state_d = sRUN;
                end
            end
            sRUN: begin
                if (STALL) begin
                    pc_d = pc_q;
                end else if (HALT_REQ) begin
                    state_d = sHALT;
                end else if (BRANCH_EN && BR_FLAG) begin
                    pc_d = lut_target;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            sHALT: begin
                if (START) begin
                    state_d = sRUN;
                    pc_d    = START_ADDR;
                end
            end
            default: begin
                state_d = sIDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    assign PC          = pc_q;
    assign FETCH_VALID = (state_q == sRUN);
    assign DONE        = (state_q == sHALT);
    assign STATE       = state_q;

`ifdef PC_PERF_EN
    logic        br_taken;
    logic        start_acc;
    logic [15:0] cnt_q;

    assign br_taken  = (state_q == sRUN) && !STALL && !HALT_REQ && BRANCH_EN && BR_FLAG;
    assign start_acc = START && (state_q != sRUN);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (br_taken && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign TAKEN_CNT = cnt_q;
`else
    assign TAKEN_CNT = 16'd0;
`endif

endmodule
